// File: rtl/tdm_demux_4ch_if.sv
// Bus bundle for the 4-channel TDM receiver: line-side inputs plus the
// recovered channels and frame status.
interface tdm_demux_4ch_if #(
    parameter int WIDTH = 1
);
    logic             en;
    logic             sync;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic [1:0]       sel;
    logic             locked;
    logic             frame_valid;
    logic             sync_err;

    // Line source / consumer side.
    modport master (
        output en, sync, din,
        input  out0, out1, out2, out3, sel, locked, frame_valid, sync_err
    );

    // Receiver side.
    modport slave (
        input  en, sync, din,
        output out0, out1, out2, out3, sel, locked, frame_valid, sync_err
    );
endinterface

// File: rtl/tdm_demux_4ch.sv
// Receive end of a 4:1 TDM line. Slots 0..2 are collected in shadow
// registers and the whole frame is published on the slot-3 edge, so the
// outputs never show a partial frame. A sync marks slot 0 and (re)aligns
// the slot counter; a sync arriving mid-frame while locked is flagged.
module tdm_demux_4ch #(
    parameter int WIDTH = 1
) (
    input  logic                clk,
    input  logic                rst,
    tdm_demux_4ch_if.slave      bus
);

    logic [WIDTH-1:0] shadow_r [0:2];
    logic [WIDTH-1:0] out_r    [0:3];
    logic [1:0]       sel_r;
    logic             locked_r;
    logic             frame_valid_r;
    logic             sync_err_r;
    logic             misaligned_s;

    // A sync is out of place only once locked and not at a frame boundary.
    assign misaligned_s = locked_r & (sel_r != 2'd0);

    // Slot counter, shadow capture, frame publish and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_r         <= 2'd0;
            locked_r      <= 1'b0;
            frame_valid_r <= 1'b0;
            sync_err_r    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                shadow_r[i] <= {WIDTH{1'b0}};
            end
            for (int i = 0; i < 4; i++) begin
                out_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            // Status flags are single-cycle pulses.
            frame_valid_r <= 1'b0;
            sync_err_r    <= 1'b0;
            if (bus.en) begin
                if (bus.sync) begin
                    // Frame start (or realignment): restart collection at slot 0
                    // and drop any partially gathered slots.
                    sync_err_r  <= misaligned_s;
                    shadow_r[0] <= bus.din;
                    shadow_r[1] <= {WIDTH{1'b0}};
                    shadow_r[2] <= {WIDTH{1'b0}};
                    sel_r       <= 2'd1;
                    locked_r    <= 1'b1;
                end else if (locked_r) begin
                    case (sel_r)
                        2'd0: shadow_r[0] <= bus.din;
                        2'd1: shadow_r[1] <= bus.din;
                        2'd2: shadow_r[2] <= bus.din;
                        2'd3: begin
                            // Last slot: publish the complete frame in one edge.
                            out_r[0]      <= shadow_r[0];
                            out_r[1]      <= shadow_r[1];
                            out_r[2]      <= shadow_r[2];
                            out_r[3]      <= bus.din;
                            frame_valid_r <= 1'b1;
                        end
                        default: sel_r <= 2'd0;
                    endcase
                    sel_r <= sel_r + 2'd1;
                end else begin
                    // Unlocked and no sync: the line carries nothing usable.
                    sel_r <= 2'd0;
                end
            end else begin
                // Enable low: hold everything except the pulses cleared above.
                sel_r <= sel_r;
            end
        end
    end

    assign bus.out0        = out_r[0];
    assign bus.out1        = out_r[1];
    assign bus.out2        = out_r[2];
    assign bus.out3        = out_r[3];
    assign bus.sel         = sel_r;
    assign bus.locked      = locked_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.sync_err    = sync_err_r;

endmodule
